irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 123 ++++++++++++
 tb/tb_irq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: MASK/PEND/ISR/CTRL registers with an IDLE/REQ/SERVICE handshake FSM.
// Define IRQ_CTRL_NEST_EN to let a higher-priority pending source preempt an in-service one.
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  output logic             int_req,
  output logic [2:0]       int_id,
  input  logic             int_ack,
  input  logic             int_eoi
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] mask_reg, pend_reg, isr_reg, prev_reg;
  logic [N_SRC-1:0] pend_next, isr_next, isr_eoi, edge_det, pend_clr, ack_clr, active;
  logic             ge_reg, armed_reg;
  logic [2:0]       id_reg, id_next;
  logic             unused_din_bits;

  // Lower index wins.
  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  assign active   = pend_reg & mask_reg;
  assign isr_eoi  = isr_reg & ~(ONE << lowest_idx(isr_reg));
  assign pend_clr = ((we && addr == 2'd1) ? din[N_SRC-1:0] : '0) | ack_clr;
  assign unused_din_bits = ^din[31:N_SRC];

  // armed_reg keeps lines that are already high at reset release from counting as edges.
  // A fresh edge beats a same-cycle clear.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign edge_det[gi]  = armed_reg & irq_src[gi] & ~prev_reg[gi];
      assign pend_next[gi] = (pend_reg[gi] & ~pend_clr[gi]) | edge_det[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      id_reg    <= 3'd0;
      mask_reg  <= '0;
      pend_reg  <= '0;
      isr_reg   <= '0;
      prev_reg  <= '0;
      ge_reg    <= 1'b0;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
      pend_reg  <= pend_next;
      isr_reg   <= isr_next;
      prev_reg  <= irq_src;
      armed_reg <= 1'b1;
      if (we && addr == 2'd0) mask_reg <= din[N_SRC-1:0];
      if (we && addr == 2'd3) ge_reg   <= din[0];
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    isr_next   = isr_reg;
    ack_clr    = '0;
    case (state_reg)
      IDLE: begin
        if (ge_reg && active != '0) begin
          state_next = REQ;
          id_next    = lowest_idx(active);
        end
      end
      // Once raised, the request is held regardless of MASK/GE until acknowledged.
      REQ: begin
        if (int_ack) begin
          ack_clr    = ONE << id_reg;
          isr_next   = isr_reg | (ONE << id_reg);
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (int_eoi) begin
          isr_next   = isr_eoi;
          state_next = (isr_eoi == '0) ? IDLE : SERVICE;
        end
`ifdef IRQ_CTRL_NEST_EN
        else if (ge_reg && active != '0 && lowest_idx(active) < lowest_idx(isr_reg)) begin
          state_next = REQ;
          id_next    = lowest_idx(active);
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign int_req = (state_reg == REQ);
  assign int_id  = int_req ? id_reg : 3'd0;

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0: dout[N_SRC-1:0] = mask_reg;
      2'd1: dout[N_SRC-1:0] = pend_reg;
      2'd2: dout[N_SRC-1:0] = isr_reg;
      default: dout[0] = ge_reg;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected reads and requests, a negedge monitor checks them.
// Honours IRQ_CTRL_NEST_EN for the preemption scenario.
module tb_irq_ctrl;

  typedef struct {
    int          sel;   // 0: dout, 1: {int_req, int_id}
    logic [31:0] exp;
    string       name;
  } probe_t;

  typedef struct {
    int id;
    int cyc;            // -1: cycle not checked
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  irq_src = '0;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack = 1'b0;
  logic        int_eoi = 1'b0;

  logic        probe_stb = 1'b0;
  probe_t      probe_q[$];
  req_t        req_q[$];
  int          cyc = 0;
  int          req_count = 0;
  logic        req_prev = 1'b0;
  int          checks = 0;
  int          errors = 0;

  irq_ctrl #(.N_SRC(6)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .addr(addr), .we(we), .din(din),
    .dout(dout), .int_req(int_req), .int_id(int_id), .int_ack(int_ack), .int_eoi(int_eoi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: compares probes and every new interrupt request against the queues.
  always @(negedge clk) begin
    probe_t p;
    req_t   r;
    if (probe_stb) begin
      if (probe_q.size() == 0) begin
        check("probe_queue_empty", 32'd1, 32'd0);
      end else begin
        p = probe_q.pop_front();
        if (p.sel == 1) check(p.name, {28'd0, int_req, int_id}, p.exp);
        else            check(p.name, dout, p.exp);
        $display("probe %s: dout/status=0x%08h", p.name, (p.sel == 1) ? {28'd0, int_req, int_id} : dout);
      end
    end
    if (int_req && !req_prev) begin
      req_count++;
      if (req_q.size() == 0) begin
        check("unexpected_req_id", {29'd0, int_id}, 32'hFFFF_FFFF);
      end else begin
        r = req_q.pop_front();
        check("req_id", {29'd0, int_id}, r.id);
        if (r.cyc >= 0) check("req_cycle", cyc, r.cyc);
        $display("request id=%0d at cycle %0d", int_id, cyc);
      end
    end
    req_prev = int_req;
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    tick();
    we = 1'b0; din = '0;
  endtask

  task automatic probe(int sel, logic [1:0] a, logic [31:0] exp, string name);
    probe_t p;
    p.sel = sel; p.exp = exp; p.name = name;
    probe_q.push_back(p);
    addr = a; probe_stb = 1'b1;
    tick();
    probe_stb = 1'b0;
  endtask

  task automatic expect_req(int id, int c);
    req_t r;
    r.id = id; r.cyc = c;
    req_q.push_back(r);
  endtask

  task automatic wait_req(int n);
    for (int k = 0; k < 40 && req_count < n; k++) tick();
    if (req_count < n) check("req_timeout", req_count, n);
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic eoi();
    int_eoi = 1'b1; tick(); int_eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    irq_src = 6'b100000;
    tick(2);
    probe(0, 2'd0, 32'h0, "rst_mask");
    probe(0, 2'd1, 32'h0, "rst_pend");
    probe(0, 2'd3, 32'h0, "rst_ctrl");
    probe(1, 2'd0, 32'h0, "rst_status");
    reset = 1'b1;
    tick(3);
    probe(0, 2'd1, 32'h0, "high_at_release_no_edge");
    irq_src = '0;

    // Basic request, exact latency, ack moves PEND to ISR.
    wr(2'd0, 32'h3F);
    wr(2'd3, 32'h1);
    probe(0, 2'd0, 32'h3F, "mask_rw");
    probe(0, 2'd3, 32'h1, "ctrl_rw");
    expect_req(2, cyc + 2);
    irq_src[2] = 1'b1;
    wait_req(1);
    probe(0, 2'd1, 32'h04, "pend_in_req");
    ack();
    probe(0, 2'd2, 32'h04, "isr_after_ack");
    probe(0, 2'd1, 32'h00, "pend_after_ack");
    probe(1, 2'd0, 32'h0, "req_dropped");
    irq_src[2] = 1'b0;
    eoi();
    probe(0, 2'd2, 32'h00, "isr_after_eoi");

    // Simultaneous edges: lowest index first.
    expect_req(1, cyc + 2);
    expect_req(4, -1);
    irq_src[1] = 1'b1; irq_src[4] = 1'b1;
    wait_req(2);
    ack(); eoi();
    wait_req(3);
    ack();
    probe(0, 2'd2, 32'h10, "isr_src4");
    eoi();
    irq_src = '0;

    // Masked source stays pending until unmasked.
    wr(2'd0, 32'h0);
    irq_src[3] = 1'b1;
    tick(3);
    probe(0, 2'd1, 32'h08, "masked_pend");
    probe(1, 2'd0, 32'h0, "masked_no_req");
    expect_req(3, cyc + 2);
    wr(2'd0, 32'h08);
    wait_req(4);
    ack(); eoi();
    irq_src = '0;

    // W1C versus same-cycle new edge.
    wr(2'd0, 32'h0);
    irq_src[0] = 1'b1;
    tick(2);
    probe(0, 2'd1, 32'h01, "pend_src0");
    irq_src[0] = 1'b0;
    tick();
    irq_src[0] = 1'b1;
    wr(2'd1, 32'h01);
    probe(0, 2'd1, 32'h01, "edge_beats_w1c");
    wr(2'd1, 32'h01);
    probe(0, 2'd1, 32'h00, "w1c_clears");
    irq_src = '0;
    wr(2'd2, 32'h3F);
    probe(0, 2'd2, 32'h00, "isr_write_ignored");

    // GE gating; MASK/GE changes do not withdraw a raised request; eoi ignored in REQ.
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h3F);
    irq_src[5] = 1'b1;
    tick(3);
    probe(1, 2'd0, 32'h0, "ge_off_no_req");
    probe(0, 2'd1, 32'h20, "ge_off_pend");
    expect_req(5, -1);
    wr(2'd3, 32'h1);
    wait_req(5);
    wr(2'd0, 32'h0);
    wr(2'd3, 32'h0);
    eoi();
    probe(1, 2'd0, 32'hD, "req_held");
    ack();
    probe(0, 2'd2, 32'h20, "isr_src5");
    eoi();
    probe(0, 2'd2, 32'h00, "isr_clear_src5");
    irq_src = '0;
    wr(2'd0, 32'h3F);
    wr(2'd3, 32'h1);
    ack();
    probe(0, 2'd2, 32'h00, "ack_idle_ignored");

    // Higher-priority edge while servicing source 3.
    expect_req(3, -1);
    irq_src[3] = 1'b1;
    wait_req(6);
    ack();
    probe(0, 2'd2, 32'h08, "isr_src3");
`ifdef IRQ_CTRL_NEST_EN
    expect_req(0, cyc + 2);
    irq_src[0] = 1'b1;
    wait_req(7);
    ack();
    probe(0, 2'd2, 32'h09, "isr_nested");
    eoi();
    probe(0, 2'd2, 32'h08, "isr_after_inner_eoi");
    eoi();
    probe(0, 2'd2, 32'h00, "isr_after_outer_eoi");
`else
    irq_src[0] = 1'b1;
    tick(4);
    probe(1, 2'd0, 32'h0, "no_preempt");
    probe(0, 2'd1, 32'h01, "pend_during_service");
    probe(0, 2'd2, 32'h08, "isr_single");
    expect_req(0, -1);
    eoi();
    wait_req(7);
    ack();
    probe(0, 2'd2, 32'h01, "isr_src0");
    eoi();
`endif
    irq_src = '0;

    // Reset in the middle of REQ.
    expect_req(4, -1);
    irq_src[4] = 1'b1;
    wait_req(8);
    reset = 1'b0;
    probe(1, 2'd0, 32'h0, "rst_mid_req_status");
    probe(0, 2'd1, 32'h0, "rst_mid_req_pend");
    probe(0, 2'd2, 32'h0, "rst_mid_req_isr");
    probe(0, 2'd0, 32'h0, "rst_mid_req_mask");
    reset = 1'b1;
    tick(3);
    probe(0, 2'd1, 32'h0, "no_edge_after_rst");

    check("req_queue_drained", req_q.size(), 0);
    check("probe_queue_drained", probe_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
